// File: rtl/param_datapath.sv
// Multi-cycle register-file ALU datapath: operands read in TA/TB, result written back in TC.
// Latency 4 edges from accepted start to done; start is ignored while busy, so the caller re-issues after done.
module param_datapath #(
   parameter int WIDTH = 32,
   parameter int NREGS = 16
) (
   input  logic                       clock,
   input  logic                       clear,
   input  logic                       start,
   input  logic [3:0]                 opcode,
   input  logic [$clog2(NREGS)-1:0]   ra,
   input  logic [$clog2(NREGS)-1:0]   rb,
   input  logic [$clog2(NREGS)-1:0]   rc,
   input  logic                       ld_en,
   input  logic [$clog2(NREGS)-1:0]   ld_addr,
   input  logic [WIDTH-1:0]           ld_data,
   input  logic [$clog2(NREGS)-1:0]   rd_addr,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       busy,
   output logic                       done,
   output logic [WIDTH-1:0]           hi,
   output logic [WIDTH-1:0]           lo
);
   localparam int AW = $clog2(NREGS);
   localparam int SW = $clog2(WIDTH);

   localparam logic [3:0] OP_ADD  = 4'd0;
   localparam logic [3:0] OP_SUB  = 4'd1;
   localparam logic [3:0] OP_AND  = 4'd2;
   localparam logic [3:0] OP_OR   = 4'd3;
   localparam logic [3:0] OP_SHL  = 4'd4;
   localparam logic [3:0] OP_SHR  = 4'd5;
   localparam logic [3:0] OP_SHRA = 4'd6;
   localparam logic [3:0] OP_NOT  = 4'd7;
   localparam logic [3:0] OP_NEG  = 4'd8;
   localparam logic [3:0] OP_MUL  = 4'd9;

   typedef enum logic [1:0] {IDLE, TA, TB, TC} state_t;

   state_t                state, state_nxt;
   logic [WIDTH-1:0]      regs [NREGS];
   logic [3:0]            op_q;
   logic [AW-1:0]         ra_q, rb_q, rc_q;
   logic [WIDTH-1:0]      y;
   logic [2*WIDTH-1:0]    z, z_nxt;
   logic [WIDTH-1:0]      b;
   logic [SW-1:0]         shamt;
   logic [2*WIDTH-1:0]    y_ext, b_ext;

   assign rd_data = regs[rd_addr];
   assign busy    = (state != IDLE);

   always_ff @(posedge clock) begin
      if (clear) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = TA;
         TA:      state_nxt = TB;
         TB:      state_nxt = TC;
         TC:      state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Sign-extending to 2*WIDTH makes the low 2*WIDTH product bits the exact signed result.
   always_comb begin
      b     = regs[rb_q];
      shamt = b[SW-1:0];
      y_ext = {{WIDTH{y[WIDTH-1]}}, y};
      b_ext = {{WIDTH{b[WIDTH-1]}}, b};
      z_nxt = '0;
      case (op_q)
         OP_ADD:  z_nxt[WIDTH-1:0] = y + b;
         OP_SUB:  z_nxt[WIDTH-1:0] = y - b;
         OP_AND:  z_nxt[WIDTH-1:0] = y & b;
         OP_OR:   z_nxt[WIDTH-1:0] = y | b;
         OP_SHL:  z_nxt[WIDTH-1:0] = y << shamt;
         OP_SHR:  z_nxt[WIDTH-1:0] = y >> shamt;
         OP_SHRA: z_nxt[WIDTH-1:0] = $signed(y) >>> shamt;
         OP_NOT:  z_nxt[WIDTH-1:0] = ~y;
         OP_NEG:  z_nxt[WIDTH-1:0] = '0 - y;
         OP_MUL:  z_nxt = y_ext * b_ext;
         default: z_nxt = '0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (clear) begin
         op_q <= '0;
         ra_q <= '0;
         rb_q <= '0;
         rc_q <= '0;
         y    <= '0;
         z    <= '0;
         hi   <= '0;
         lo   <= '0;
         done <= 1'b0;
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
      end else begin
         done <= (state == TC);
         if (state == IDLE && start) begin
            op_q <= opcode;
            ra_q <= ra;
            rb_q <= rb;
            rc_q <= rc;
         end
         if (state == TA) y <= regs[ra_q];
         if (state == TB) z <= z_nxt;
         if (ld_en) regs[ld_addr] <= ld_data;
         // Writeback is placed after the external load so it wins on an address collision.
         if (state == TC) begin
            if (op_q == OP_MUL) begin
               hi <= z[2*WIDTH-1:WIDTH];
               lo <= z[WIDTH-1:0];
            end else begin
               regs[rc_q] <= z[WIDTH-1:0];
            end
         end
      end
   end
endmodule

// File: tb/tb_param_datapath.sv
// Directed bench for param_datapath: default 32x16 instance plus an 8-bit, 4-register instance.
module tb_param_datapath;
   logic        clock = 1'b0;
   logic        clear, start, ld_en;
   logic [3:0]  opcode, ra, rb, rc, ld_addr, rd_addr;
   logic [31:0] ld_data, rd_data, hi, lo;
   logic        busy, done;

   logic        clear8, start8, ld_en8;
   logic [3:0]  opcode8;
   logic [1:0]  ra8, rb8, rc8, ld_addr8, rd_addr8;
   logic [7:0]  ld_data8, rd_data8, hi8, lo8;
   logic        busy8, done8;

   int checks = 0;
   int passed = 0;

   always #5 clock = ~clock;

   param_datapath dut (
      .clock(clock), .clear(clear), .start(start), .opcode(opcode),
      .ra(ra), .rb(rb), .rc(rc), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
      .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done), .hi(hi), .lo(lo)
   );

   param_datapath #(.WIDTH(8), .NREGS(4)) dut8 (
      .clock(clock), .clear(clear8), .start(start8), .opcode(opcode8),
      .ra(ra8), .rb(rb8), .rc(rc8), .ld_en(ld_en8), .ld_addr(ld_addr8), .ld_data(ld_data8),
      .rd_addr(rd_addr8), .rd_data(rd_data8), .busy(busy8), .done(done8), .hi(hi8), .lo(lo8)
   );

   task automatic load(input logic [3:0] addr, input logic [31:0] data);
      ld_en = 1'b1; ld_addr = addr; ld_data = data;
      @(posedge clock); #1;
      ld_en = 1'b0;
   endtask

   // Issues one operation and returns #1 after the edge that raises done.
   task automatic run_op(input logic [3:0] op, input logic [3:0] a, input logic [3:0] bb,
                         input logic [3:0] c);
      bit got = 0;
      start = 1'b1; opcode = op; ra = a; rb = bb; rc = c;
      @(posedge clock); #1;
      start = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clock); #1;
         if (done) begin got = 1; break; end
      end
      checks++;
      if (!got) $display("FAIL op_timeout op=%0d: done not seen, required within 8 cycles", op);
      else passed++;
   endtask

   task automatic test_reset();
      clear = 1'b1; clear8 = 1'b1;
      @(posedge clock); #1;
      @(posedge clock); #1;
      clear = 1'b0; clear8 = 1'b0;
      rd_addr = 4'd0; rd_addr8 = 2'd0;
      #1;
      checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else passed++;
      checks++; if (done !== 1'b0) $display("FAIL reset_done got %b want 0", done); else passed++;
      checks++; if (hi !== 32'h0) $display("FAIL reset_hi got %h want 0", hi); else passed++;
      checks++; if (lo !== 32'h0) $display("FAIL reset_lo got %h want 0", lo); else passed++;
      checks++; if (rd_data !== 32'h0) $display("FAIL reset_r0 got %h want 0", rd_data); else passed++;
      checks++; if (busy8 !== 1'b0 || done8 !== 1'b0)
         $display("FAIL reset_w8 got busy=%b done=%b want 0 0", busy8, done8); else passed++;
   endtask

   task automatic test_and();
      int n = 0;
      load(4'd2, 32'h0000_0022);
      load(4'd3, 32'h0000_0024);
      rd_addr = 4'd1;
      start = 1'b1; opcode = 4'd2; ra = 4'd2; rb = 4'd3; rc = 4'd1;
      @(posedge clock); #1;
      start = 1'b0;
      checks++; if (busy !== 1'b1) $display("FAIL and_busy_ta got %b want 1", busy); else passed++;
      for (int i = 1; i <= 8; i++) begin
         @(posedge clock); #1;
         if (done) begin n = i; break; end
      end
      checks++; if (n !== 3) $display("FAIL and_latency got %0d want 3", n); else passed++;
      checks++; if (busy !== 1'b0) $display("FAIL and_busy_done got %b want 0", busy); else passed++;
      checks++; if (rd_data !== 32'h0000_0020) $display("FAIL and_result got %h want 00000020", rd_data); else passed++;
      @(posedge clock); #1;
      checks++; if (done !== 1'b0) $display("FAIL and_done_pulse got %b want 0", done); else passed++;
   endtask

   task automatic test_add_sub();
      load(4'd4, 32'hFFFF_FFFF);
      load(4'd5, 32'h0000_0001);
      rd_addr = 4'd6;
      run_op(4'd0, 4'd4, 4'd5, 4'd6);
      checks++; if (rd_data !== 32'h0) $display("FAIL add_wrap got %h want 00000000", rd_data); else passed++;
      rd_addr = 4'd11;
      run_op(4'd1, 4'd5, 4'd4, 4'd11);
      checks++; if (rd_data !== 32'h2) $display("FAIL sub_wrap got %h want 00000002", rd_data); else passed++;
   endtask

   task automatic test_shift();
      load(4'd7, 32'h8000_0000);
      load(4'd8, 32'h0000_0024);
      rd_addr = 4'd12;
      run_op(4'd6, 4'd7, 4'd8, 4'd12);
      checks++; if (rd_data !== 32'hF800_0000) $display("FAIL shra got %h want f8000000", rd_data); else passed++;
      rd_addr = 4'd13;
      run_op(4'd5, 4'd7, 4'd8, 4'd13);
      checks++; if (rd_data !== 32'h0800_0000) $display("FAIL shr got %h want 08000000", rd_data); else passed++;
      rd_addr = 4'd14;
      run_op(4'd4, 4'd7, 4'd8, 4'd14);
      checks++; if (rd_data !== 32'h0) $display("FAIL shl got %h want 00000000", rd_data); else passed++;
   endtask

   task automatic test_mul();
      load(4'd9, 32'hFFFF_FFFE);
      load(4'd10, 32'h0000_0003);
      load(4'd15, 32'h1234_5678);
      rd_addr = 4'd15;
      run_op(4'd9, 4'd9, 4'd10, 4'd15);
      checks++; if (hi !== 32'hFFFF_FFFF) $display("FAIL mul_hi got %h want ffffffff", hi); else passed++;
      checks++; if (lo !== 32'hFFFF_FFFA) $display("FAIL mul_lo got %h want fffffffa", lo); else passed++;
      checks++; if (rd_data !== 32'h1234_5678) $display("FAIL mul_rc got %h want 12345678", rd_data); else passed++;
   endtask

   task automatic test_unary_illegal_alias();
      rd_addr = 4'd11;
      run_op(4'd7, 4'd2, 4'd4, 4'd11);
      checks++; if (rd_data !== 32'hFFFF_FFDD) $display("FAIL not got %h want ffffffdd", rd_data); else passed++;
      rd_addr = 4'd12;
      run_op(4'd8, 4'd3, 4'd4, 4'd12);
      checks++; if (rd_data !== 32'hFFFF_FFDC) $display("FAIL neg got %h want ffffffdc", rd_data); else passed++;
      rd_addr = 4'd13;
      run_op(4'd12, 4'd2, 4'd3, 4'd13);
      checks++; if (rd_data !== 32'h0) $display("FAIL illegal_op got %h want 00000000", rd_data); else passed++;
      rd_addr = 4'd2;
      run_op(4'd0, 4'd2, 4'd3, 4'd2);
      checks++; if (rd_data !== 32'h0000_0046) $display("FAIL rc_eq_ra got %h want 00000046", rd_data); else passed++;
   endtask

   task automatic test_ld_with_start();
      bit got = 0;
      rd_addr = 4'd0;
      ld_en = 1'b1; ld_addr = 4'd14; ld_data = 32'h0000_0010;
      start = 1'b1; opcode = 4'd0; ra = 4'd14; rb = 4'd5; rc = 4'd0;
      @(posedge clock); #1;
      start = 1'b0; ld_en = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clock); #1;
         if (done) begin got = 1; break; end
      end
      checks++; if (!got) $display("FAIL ld_start_timeout done not seen within 8 cycles"); else passed++;
      checks++; if (rd_data !== 32'h0000_0011) $display("FAIL ld_start got %h want 00000011", rd_data); else passed++;
   endtask

   task automatic test_back_to_back_ignore();
      int dones = 0;
      rd_addr = 4'd3;
      start = 1'b1; opcode = 4'd0; ra = 4'd5; rb = 4'd5; rc = 4'd3;
      @(posedge clock); #1;
      opcode = 4'd2; rc = 4'd4;
      @(posedge clock); #1;
      @(posedge clock); #1;
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(posedge clock); #1;
         if (done) dones++;
      end
      checks++; if (dones !== 1) $display("FAIL ignore_start done_count got %0d want 1", dones); else passed++;
      checks++; if (rd_data !== 32'h2) $display("FAIL ignore_start result got %h want 00000002", rd_data); else passed++;
   endtask

   task automatic test_clear_mid_op();
      int dones = 0;
      rd_addr = 4'd4;
      start = 1'b1; opcode = 4'd0; ra = 4'd5; rb = 4'd5; rc = 4'd4;
      @(posedge clock); #1;
      start = 1'b0;
      @(posedge clock); #1;
      clear = 1'b1;
      @(posedge clock); #1;
      clear = 1'b0;
      checks++; if (busy !== 1'b0) $display("FAIL clear_busy got %b want 0", busy); else passed++;
      checks++; if (done !== 1'b0) $display("FAIL clear_done got %b want 0", done); else passed++;
      checks++; if (rd_data !== 32'h0) $display("FAIL clear_rc got %h want 00000000", rd_data); else passed++;
      checks++; if (hi !== 32'h0 || lo !== 32'h0) $display("FAIL clear_hilo got %h %h want 0 0", hi, lo); else passed++;
      for (int i = 0; i < 6; i++) begin
         @(posedge clock); #1;
         if (done) dones++;
      end
      checks++; if (dones !== 0) $display("FAIL clear_no_done got %0d want 0", dones); else passed++;
   endtask

   task automatic test_width8();
      ld_en8 = 1'b1; ld_addr8 = 2'd0; ld_data8 = 8'h7F;
      @(posedge clock); #1;
      ld_addr8 = 2'd1; ld_data8 = 8'h01;
      @(posedge clock); #1;
      ld_en8 = 1'b0;
      rd_addr8 = 2'd0;
      start8 = 1'b1; opcode8 = 4'd0; ra8 = 2'd0; rb8 = 2'd1; rc8 = 2'd0;
      @(posedge clock); #1;
      start8 = 1'b0;
      @(posedge clock); #1;
      @(posedge clock); #1;
      ld_en8 = 1'b1; ld_addr8 = 2'd0; ld_data8 = 8'h55;
      @(posedge clock); #1;
      ld_en8 = 1'b0;
      checks++; if (done8 !== 1'b1) $display("FAIL w8_done got %b want 1", done8); else passed++;
      checks++; if (rd_data8 !== 8'h80) $display("FAIL w8_wb_wins got %h want 80", rd_data8); else passed++;
   endtask

   initial begin
      clear = 1'b1; start = 1'b0; ld_en = 1'b0; opcode = '0; ra = '0; rb = '0; rc = '0;
      ld_addr = '0; ld_data = '0; rd_addr = '0;
      clear8 = 1'b1; start8 = 1'b0; ld_en8 = 1'b0; opcode8 = '0; ra8 = '0; rb8 = '0; rc8 = '0;
      ld_addr8 = '0; ld_data8 = '0; rd_addr8 = '0;
      #1;
      test_reset();
      test_and();
      test_add_sub();
      test_shift();
      test_mul();
      test_unary_illegal_alias();
      test_ld_with_start();
      test_back_to_back_ignore();
      test_clear_mid_op();
      test_width8();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
